// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: FSM state encoding,
// opcode constants and B-type immediate extraction.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // B-immediate from instr[31:25] and instr[11:7]; bit 0 is always zero.
  function automatic logic signed [12:0] b_imm(input logic [31:25] hi, input logic [11:7] lo);
    return $signed({hi[31], lo[7], hi[30:25], lo[11:8], 1'b0});
  endfunction

  // Backward-taken candidate: conditional branch whose immediate sign bit is set.
  function automatic logic is_btfn(input logic [6:0] opcode, input logic sign);
    return (opcode == OPC_BRANCH) && sign;
  endfunction

endpackage

// File: rtl/fetch_holdbuf.sv
// One-entry skid buffer that parks an instruction response arriving while the
// IF/ID register is stalled.
module fetch_holdbuf #(
  parameter int WORD_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     load,
  input  logic                     drain,
  input  logic [WORD_BITWIDTH-1:0] load_pc,
  input  logic [WORD_BITWIDTH-1:0] load_instr,
  output logic                     valid,
  output logic [WORD_BITWIDTH-1:0] pc,
  output logic [WORD_BITWIDTH-1:0] instr
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester feeding the IF/ID
// register. Define STATIC_BTFN_EN to enable backward-taken branch prediction.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                       WORD_BITWIDTH    = 32,
  parameter int                       REG_NUM_BITWIDTH = 5,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC         = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pc_stall,
  input  logic                        if_stall,
  input  logic                        ex_redirect,
  input  logic [WORD_BITWIDTH-1:0]    ex_target,
  output logic                        imem_req,
  output logic [WORD_BITWIDTH-1:0]    imem_addr,
  input  logic                        imem_ready,
  input  logic                        imem_rvalid,
  input  logic [WORD_BITWIDTH-1:0]    imem_rdata,
  output logic                        if_valid,
  output logic [WORD_BITWIDTH-1:0]    if_pc,
  output logic [WORD_BITWIDTH-1:0]    if_instr,
  output logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
  output logic [REG_NUM_BITWIDTH-1:0] if_Rs2,
  output logic                        if_pred_taken
);

  fetch_state_e                    state_q, state_d;
  logic [WORD_BITWIDTH-1:0]        pc_q;
  logic                            handshake;
  logic                            hb_valid, hb_load, hb_drain;
  logic [WORD_BITWIDTH-1:0]        hb_pc, hb_instr;
  logic                            from_hold, deliver;
  logic [WORD_BITWIDTH-1:0]        dlv_pc, dlv_instr, pc_next, redirect_pc;
  logic signed [WORD_BITWIDTH-1:0] pc_step;

  assign handshake   = imem_req && imem_ready;
  assign from_hold   = (state_q == ST_HOLD) && hb_valid;
  // A redirect squashes whatever would have been delivered this cycle.
  assign deliver     = !if_stall && !ex_redirect &&
                       (from_hold || ((state_q == ST_WAIT) && imem_rvalid));
  assign dlv_pc      = from_hold ? hb_pc : pc_q;
  assign dlv_instr   = from_hold ? hb_instr : imem_rdata;
  assign hb_load     = (state_q == ST_WAIT) && imem_rvalid && if_stall && !ex_redirect;
  assign hb_drain    = (state_q == ST_HOLD) && !if_stall;
  assign redirect_pc = ex_target & ~WORD_BITWIDTH'(3);
  assign pc_next     = dlv_pc + $unsigned(pc_step);

  fetch_holdbuf #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_holdbuf (
    .clk        (clk),
    .rst        (rst),
    .flush      (ex_redirect),
    .load       (hb_load),
    .drain      (hb_drain),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .valid      (hb_valid),
    .pc         (hb_pc),
    .instr      (hb_instr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:  if (handshake) state_d = ex_redirect ? ST_KILL : ST_WAIT;
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_d = (if_stall && !ex_redirect) ? ST_HOLD : ST_REQ;
        end else if (ex_redirect) begin
          state_d = ST_KILL;
        end
      end
      ST_HOLD: if (ex_redirect || !if_stall) state_d = ST_REQ;
      ST_KILL: if (imem_rvalid) state_d = ST_REQ;
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == ST_REQ) && !pc_stall && !rst;
    imem_addr = pc_q;
  end

  // PC tracks the instruction in flight; it advances only once that instruction is delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (ex_redirect) begin
      pc_q <= redirect_pc;
    end else if (deliver) begin
      pc_q <= pc_next;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else if (ex_redirect) begin
      if_valid <= 1'b0;
    end else if (!if_stall) begin
      if_valid <= deliver;
      if (deliver) begin
        if_pc    <= dlv_pc;
        if_instr <= dlv_instr;
      end
    end
  end

  assign if_Rs1 = if_instr[19:15];
  assign if_Rs2 = if_instr[24:20];

`ifdef STATIC_BTFN_EN
  logic dlv_pred;
  logic pred_q;

  assign dlv_pred = is_btfn(dlv_instr[6:0], dlv_instr[31]);
  assign pc_step  = dlv_pred ? WORD_BITWIDTH'(b_imm(dlv_instr[31:25], dlv_instr[11:7]))
                             : WORD_BITWIDTH'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pred_q <= 1'b0;
    end else if (!ex_redirect && !if_stall && deliver) begin
      pred_q <= dlv_pred;
    end
  end

  assign if_pred_taken = pred_q;
`else
  assign pc_step       = WORD_BITWIDTH'(4);
  assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// scored against an instruction-stream reference model and a bench-side memory.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, pc_stall, if_stall, ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid, if_pred_taken;
  logic [31:0] if_pc, if_instr;
  logic [4:0]  if_Rs1, if_Rs2;

  fetch_stage #(
    .WORD_BITWIDTH   (32),
    .REG_NUM_BITWIDTH(5),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_stall     (pc_stall),
    .if_stall     (if_stall),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_Rs1       (if_Rs1),
    .if_Rs2       (if_Rs2),
    .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          mem_mode = 0;
  bit          rand_delay = 0;
  int          fix_delay = 0;
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  logic [31:0] hs_q[$];
  logic [31:0] exp_pc = RESET_PC;
  int          consumed = 0;

  logic        o_req, o_valid, o_pred;
  logic [31:0] o_addr, o_pc, o_instr;
  logic [4:0]  o_rs1, o_rs2;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hFE00_0EE3;
    if (mem_mode == 0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic model_pred(input logic [31:0] instr);
`ifdef STATIC_BTFN_EN
    return (instr[6:0] == 7'b1100011) && instr[31];
`else
    return 1'b0 & instr[0];
`endif
  endfunction

  // Next fetch address after delivering instr at pc.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr);
    int imm;
    if (model_pred(instr)) begin
      imm = int'(instr[11:8]) * 2 + int'(instr[30:25]) * 32 + int'(instr[7]) * 2048 - 4096;
      return pc + 32'(imm);
    end
    return pc + 32'd4;
  endfunction

  // One clock cycle: drive at negedge, memory responds, sample, score.
  task automatic cycle(input logic r, input logic ps, input logic ifs, input logic rdy,
                       input logic red, input logic [31:0] tgt);
    logic [31:0] want;
    @(negedge clk);
    rst = r; pc_stall = ps; if_stall = ifs; imem_ready = rdy;
    ex_redirect = red; ex_target = tgt;
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    if (r) begin
      mem_pend = 1'b0;
    end else if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(mem_addr); mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    #1;
    o_req = imem_req; o_addr = imem_addr; o_valid = if_valid; o_pc = if_pc;
    o_instr = if_instr; o_pred = if_pred_taken; o_rs1 = if_Rs1; o_rs2 = if_Rs2;
    if (o_req && rdy) begin
      tests++;
      if (mem_pend) begin
        fails++;
        $display("FAIL outstanding: second request addr=%h while %h still pending", o_addr, mem_addr);
      end
      mem_pend = 1'b1; mem_addr = o_addr;
      mem_cnt = rand_delay ? $urandom_range(3, 0) : fix_delay;
      hs_q.push_back(o_addr);
    end
    if (r) begin
      exp_pc = RESET_PC;
    end else begin
      if (o_valid && !ifs) begin
        tests++; consumed++;
        want = mem_word(exp_pc);
        if (o_pc !== exp_pc || o_instr !== want || o_rs1 !== want[19:15] ||
            o_rs2 !== want[24:20] || o_pred !== model_pred(want)) begin
          fails++;
          $display("FAIL stream: pc=%h instr=%h rs1=%0d rs2=%0d pred=%b, required pc=%h instr=%h rs1=%0d rs2=%0d pred=%b",
                   o_pc, o_instr, o_rs1, o_rs2, o_pred, exp_pc, want, want[19:15], want[24:20], model_pred(want));
        end
        exp_pc = model_next(exp_pc, want);
      end
      if (red) exp_pc = {tgt[31:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 1, 0, '0);
    cycle(1, 0, 0, 1, 0, '0);
    hs_q.delete();
  endtask

  task automatic test_reset();
    mem_mode = 0; rand_delay = 0; fix_delay = 0;
    do_reset();
    tests++;
    if (o_req !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_pred !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h pred=%b, required 0 0 0 0 0",
               o_req, o_valid, o_pc, o_instr, o_pred);
    end
    cycle(0, 0, 0, 1, 0, '0);
    tests++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
      fails++;
      $display("FAIL reset_release: req=%b addr=%h, required 1 %h", o_req, o_addr, RESET_PC);
    end
  endtask

  task automatic test_basic();
    int          first_c = 0;
    logic [31:0] f_pc = '0, f_instr = '0;
    logic [4:0]  f_rs1 = '0, f_rs2 = '0;
    mem_mode = 0; fix_delay = 0;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      cycle(0, 0, 0, 1, 0, '0);
      if (o_valid && first_c == 0) begin
        first_c = c; f_pc = o_pc; f_instr = o_instr; f_rs1 = o_rs1; f_rs2 = o_rs2;
      end
    end
    tests++;
    if (hs_q.size() < 3) begin
      fails++;
      $display("FAIL basic_addr_count: %0d requests, required at least 3", hs_q.size());
    end else if (hs_q[0] !== 32'h0 || hs_q[1] !== 32'h4 || hs_q[2] !== 32'h8) begin
      fails++;
      $display("FAIL basic_addr_seq: %h %h %h, required 0 4 8", hs_q[0], hs_q[1], hs_q[2]);
    end
    tests++;
    if (first_c != 3 || f_pc !== 32'h0 || f_instr !== 32'h0050_0093 || f_rs1 !== 5'd0 || f_rs2 !== 5'd5) begin
      fails++;
      $display("FAIL basic_first: cycle=%0d pc=%h instr=%h rs1=%0d rs2=%0d, required 3 0 00500093 0 5",
               first_c, f_pc, f_instr, f_rs1, f_rs2);
    end
  endtask

  task automatic test_stall();
    logic ifs;
    mem_mode = 1; fix_delay = 0;
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      ifs = (c >= 3 && c <= 6);
      cycle(0, 0, ifs, 1, 0, '0);
      if (c >= 4 && c <= 6) begin
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0) begin
          fails++;
          $display("FAIL stall_hold c%0d: valid=%b pc=%h, required 1 0", c, o_valid, o_pc);
        end
      end
      if (c == 5 || c == 6) begin
        tests++;
        if (o_req !== 1'b0) begin
          fails++;
          $display("FAIL stall_noreq c%0d: req=%b, required 0", c, o_req);
        end
      end
      if (c == 8) begin
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instr !== mem_word(32'h4) || o_addr !== 32'h8 || o_req !== 1'b1) begin
          fails++;
          $display("FAIL stall_release: valid=%b pc=%h instr=%h req=%b addr=%h, required 1 4 %h 1 8",
                   o_valid, o_pc, o_instr, o_req, o_addr, mem_word(32'h4));
        end
      end
      if (c == 10) begin
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'h8) begin
          fails++;
          $display("FAIL stall_next: valid=%b pc=%h, required 1 8", o_valid, o_pc);
        end
      end
    end
  endtask

  task automatic test_redirect();
    mem_mode = 1; fix_delay = 0;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) fix_delay = 2;
      if (c == 7) fix_delay = 0;
      cycle(0, 0, (c == 3 || c == 4), 1, (c == 4), (c == 4) ? 32'h0000_0102 : 32'h0);
      if (c == 5 || c == 6) begin
        tests++;
        if (o_valid !== 1'b0 || o_req !== 1'b0) begin
          fails++;
          $display("FAIL redirect_kill c%0d: valid=%b req=%b, required 0 0", c, o_valid, o_req);
        end
      end
      if (c == 7) begin
        tests++;
        if (o_req !== 1'b1 || o_addr !== 32'h0000_0100 || o_valid !== 1'b0) begin
          fails++;
          $display("FAIL redirect_addr: req=%b addr=%h valid=%b, required 1 00000100 0", o_req, o_addr, o_valid);
        end
      end
      if (c == 9) begin
        tests++;
        if (o_valid !== 1'b1 || o_pc !== 32'h0000_0100 || o_instr !== mem_word(32'h100)) begin
          fails++;
          $display("FAIL redirect_deliver: valid=%b pc=%h instr=%h, required 1 00000100 %h",
                   o_valid, o_pc, o_instr, mem_word(32'h100));
        end
      end
    end
  endtask

  task automatic test_wrap();
    mem_mode = 1; fix_delay = 0;
    do_reset();
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    for (int c = 2; c <= 6; c++) cycle(0, 0, 0, 1, 0, '0);
    tests++;
    if (hs_q.size() < 2) begin
      fails++;
      $display("FAIL wrap_count: %0d requests, required at least 2", hs_q.size());
    end else if (hs_q[0] !== 32'hFFFF_FFFC || hs_q[1] !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: %h %h, required fffffffc 00000000", hs_q[0], hs_q[1]);
    end
  endtask

  task automatic test_btfn();
    logic [31:0] want_addr;
    logic        want_pred;
`ifdef STATIC_BTFN_EN
    want_addr = 32'h3C; want_pred = 1'b1;
`else
    want_addr = 32'h44; want_pred = 1'b0;
`endif
    mem_mode = 0; fix_delay = 0;
    do_reset();
    cycle(0, 0, 0, 0, 1, 32'h0000_0040);
    cycle(0, 0, 0, 1, 0, '0);
    cycle(0, 0, 0, 1, 0, '0);
    cycle(0, 0, 0, 1, 0, '0);
    tests++;
    if (o_valid !== 1'b1 || o_pc !== 32'h40 || o_pred !== want_pred || o_req !== 1'b1 || o_addr !== want_addr) begin
      fails++;
      $display("FAIL btfn: valid=%b pc=%h pred=%b req=%b addr=%h, required 1 00000040 %b 1 %h",
               o_valid, o_pc, o_pred, o_req, o_addr, want_pred, want_addr);
    end
  endtask

  task automatic test_random();
    logic        r, red;
    logic [31:0] tgt;
    mem_mode = 1; rand_delay = 1;
    do_reset();
    consumed = 0;
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(299, 0) == 0);
      red = !r && ($urandom_range(24, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15, 0)
                                       : 32'($urandom_range(4095, 0));
      cycle(r, ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0),
            ($urandom_range(3, 0) != 0), red, tgt);
    end
    rand_delay = 0;
    tests++;
    if (consumed < 100) begin
      fails++;
      $display("FAIL random_progress: %0d instructions delivered, required at least 100", consumed);
    end
  endtask

  initial begin
    rst = 1'b1; pc_stall = 1'b0; if_stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_btfn();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
